mcc_xbar_seq: RTL and testbench

- Parametrised next-generation memristor-crossbar controller (MCC).
- Buffers one X sub-vector and one diagonal of B values, then runs a programming phase and an evaluation phase on the crossbar.
- Steers column muxes per diagonal and accumulates ADC results into Y lanes across diagonals.
- Sits between the host load interface and the crossbar DAC/ADC/mux analog front end.

---
 rtl/mcc_xbar_seq.sv | 164 ++++++++++++++++
 tb/tb_mcc_xbar_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcc_xbar_seq.sv
// Memristor-crossbar sequencer: buffers an X sub-vector and one B diagonal, programs
// the crossbar, evaluates it, and accumulates ADC results into Y lanes across diagonals.
//
//   state | meaning
//   IDLE  | accept X/B loads and commits; start once a diagonal and a full X are held
//   PROG  | drive staged B to the DAC in program mode for PROG_ITERS cycles
//   EVAL  | drive rotated X in read mode; wait for the ADC strobe
//   ACC   | saturating add of the captured ADC lanes into the Y accumulators
//   DONE  | Y block complete; accumulators and X clear on exit
module mcc_xbar_seq #(
    parameter int XBAR_SIZE     = 32,
    parameter int XBAR_SIZE_BIN = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int ACC_WIDTH     = 20,
    parameter int PROG_ITERS    = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                b_value_in,
    input  logic [XBAR_SIZE_BIN-1:0]             b_offset_in,
    input  logic                                 b_valid_in,
    input  logic [XBAR_SIZE_BIN-1:0]             b_diag_in,
    input  logic                                 last_diag_in,
    input  logic                                 block_valid_in,
    input  logic [DATA_WIDTH-1:0]                x_value_in,
    input  logic                                 x_valid_in,
    output logic                                 load_ready,
    output logic [DATA_WIDTH*XBAR_SIZE-1:0]      dac_out,
    output logic                                 dac_valid_out,
    output logic                                 dac_mode_out,
    input  logic [DATA_WIDTH*XBAR_SIZE-1:0]      adc_in,
    input  logic                                 adc_valid_in,
    output logic [XBAR_SIZE_BIN*XBAR_SIZE-1:0]   mux_sel,
    output logic [ACC_WIDTH*XBAR_SIZE-1:0]       y_values_out,
    output logic                                 y_values_valid
);

    localparam int IW = (PROG_ITERS > 1) ? $clog2(PROG_ITERS) : 1;

    typedef enum logic [2:0] {IDLE, PROG, EVAL, ACC, DONE} state_t;

    state_t                   state;
    logic [DATA_WIDTH-1:0]    staging [XBAR_SIZE];
    logic [DATA_WIDTH-1:0]    x_buf   [XBAR_SIZE];
    logic [DATA_WIDTH-1:0]    adc_cap [XBAR_SIZE];
    logic [ACC_WIDTH-1:0]     acc     [XBAR_SIZE];
    logic [ACC_WIDTH-1:0]     acc_next[XBAR_SIZE];
    logic [ACC_WIDTH:0]       acc_sum [XBAR_SIZE];
    logic [XBAR_SIZE_BIN-1:0] rot_idx [XBAR_SIZE];
    logic [XBAR_SIZE_BIN-1:0] x_cnt;
    logic [XBAR_SIZE_BIN-1:0] diag;
    logic                     x_full;
    logic                     blk_ok;
    logic                     last;
    logic [IW-1:0]            iter_cnt;
    logic                     drive_en;

    assign drive_en = (state == PROG) || (state == EVAL);

    for (genvar i = 0; i < XBAR_SIZE; i++) begin : g_lane
        // Index arithmetic wraps naturally because XBAR_SIZE is a power of two.
        assign rot_idx[i]  = XBAR_SIZE_BIN'(i) + diag;
        assign acc_sum[i]  = {1'b0, acc[i]} + (ACC_WIDTH+1)'(adc_cap[i]);
        assign acc_next[i] = acc_sum[i][ACC_WIDTH] ? '1 : acc_sum[i][ACC_WIDTH-1:0];

        assign mux_sel[i*XBAR_SIZE_BIN +: XBAR_SIZE_BIN] = drive_en ? rot_idx[i] : '0;
        assign dac_out[i*DATA_WIDTH +: DATA_WIDTH] =
            (state == PROG) ? staging[i] :
            (state == EVAL) ? x_buf[rot_idx[i]] : '0;
        assign y_values_out[i*ACC_WIDTH +: ACC_WIDTH] = acc[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            load_ready     <= 1'b1;
            dac_valid_out  <= 1'b0;
            dac_mode_out   <= 1'b0;
            y_values_valid <= 1'b0;
            x_cnt          <= '0;
            diag           <= '0;
            x_full         <= 1'b0;
            blk_ok         <= 1'b0;
            last           <= 1'b0;
            iter_cnt       <= '0;
            for (int i = 0; i < XBAR_SIZE; i++) begin
                staging[i] <= '0;
                x_buf[i]   <= '0;
                adc_cap[i] <= '0;
                acc[i]     <= '0;
            end
        end else begin
            y_values_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (x_valid_in && !x_full) begin
                        x_buf[x_cnt] <= x_value_in;
                        if (x_cnt == XBAR_SIZE_BIN'(XBAR_SIZE - 1)) begin
                            x_cnt  <= '0;
                            x_full <= 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                    if (b_valid_in)
                        staging[b_offset_in] <= b_value_in;
                    if (blk_ok && x_full) begin
                        state         <= PROG;
                        blk_ok        <= 1'b0;
                        iter_cnt      <= IW'(PROG_ITERS - 1);
                        load_ready    <= 1'b0;
                        dac_valid_out <= 1'b1;
                        dac_mode_out  <= 1'b0;
                    end
                    if (block_valid_in) begin
                        blk_ok <= 1'b1;
                        diag   <= b_diag_in;
                        last   <= last_diag_in;
                    end
                end
                PROG: begin
                    if (iter_cnt == '0) begin
                        state        <= EVAL;
                        dac_mode_out <= 1'b1;
                    end else begin
                        iter_cnt <= iter_cnt - 1'b1;
                    end
                end
                EVAL: begin
                    if (adc_valid_in) begin
                        for (int i = 0; i < XBAR_SIZE; i++)
                            adc_cap[i] <= adc_in[i*DATA_WIDTH +: DATA_WIDTH];
                        state         <= ACC;
                        dac_valid_out <= 1'b0;
                        dac_mode_out  <= 1'b0;
                    end
                end
                ACC: begin
                    for (int i = 0; i < XBAR_SIZE; i++)
                        acc[i] <= acc_next[i];
                    if (last) begin
                        state          <= DONE;
                        y_values_valid <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        load_ready <= 1'b1;
                    end
                end
                DONE: begin
                    for (int i = 0; i < XBAR_SIZE; i++)
                        acc[i] <= '0;
                    x_full     <= 1'b0;
                    state      <= IDLE;
                    load_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcc_xbar_seq.sv
// Scoreboard bench for mcc_xbar_seq: stimulus queues expected DAC/Y responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mcc_xbar_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  b_value_in;
    logic [1:0]  b_offset_in;
    logic        b_valid_in;
    logic [1:0]  b_diag_in;
    logic        last_diag_in;
    logic        block_valid_in;
    logic [7:0]  x_value_in;
    logic        x_valid_in;
    logic        load_ready;
    logic [31:0] dac_out;
    logic        dac_valid_out;
    logic        dac_mode_out;
    logic [31:0] adc_in;
    logic        adc_valid_in;
    logic [7:0]  mux_sel;
    logic [39:0] y_values_out;
    logic        y_values_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [40:0] exp_dac[$];
    logic [39:0] exp_y[$];

    always #5 clk = ~clk;

    mcc_xbar_seq #(
        .XBAR_SIZE(4), .XBAR_SIZE_BIN(2), .DATA_WIDTH(8), .ACC_WIDTH(10), .PROG_ITERS(3)
    ) dut (
        .clk(clk), .rst(rst),
        .b_value_in(b_value_in), .b_offset_in(b_offset_in), .b_valid_in(b_valid_in),
        .b_diag_in(b_diag_in), .last_diag_in(last_diag_in), .block_valid_in(block_valid_in),
        .x_value_in(x_value_in), .x_valid_in(x_valid_in), .load_ready(load_ready),
        .dac_out(dac_out), .dac_valid_out(dac_valid_out), .dac_mode_out(dac_mode_out),
        .adc_in(adc_in), .adc_valid_in(adc_valid_in), .mux_sel(mux_sel),
        .y_values_out(y_values_out), .y_values_valid(y_values_valid)
    );

    function automatic logic [31:0] pd(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic logic [7:0] pm(input int a0, input int a1, input int a2, input int a3);
        return {a3[1:0], a2[1:0], a1[1:0], a0[1:0]};
    endfunction

    function automatic logic [39:0] py(input int a0, input int a1, input int a2, input int a3);
        return {a3[9:0], a2[9:0], a1[9:0], a0[9:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DAC-valid cycle and every Y strobe must match the next queued entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (dac_valid_out) begin
                if (exp_dac.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dac_unexpected: got %h expected none", {dac_mode_out, dac_out, mux_sel});
                end else begin
                    check("dac_mode_data_mux", 64'({dac_mode_out, dac_out, mux_sel}), 64'(exp_dac.pop_front()));
                end
            end else begin
                check("dac_idle", 64'({dac_mode_out, dac_out, mux_sel}), 64'(0));
            end
            if (y_values_valid) begin
                if (exp_y.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL y_unexpected: got %h expected none", y_values_out);
                end else begin
                    check("y_values", 64'(y_values_out), 64'(exp_y.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 = dac_valid_out, 1 = dac_mode_out, 2 = load_ready
    task automatic wait_high(input int sel, input string name);
        bit seen = 0;
        for (int n = 0; n < 64 && !seen; n++) begin
            step();
            seen = (sel == 0) ? dac_valid_out : (sel == 1) ? dac_mode_out : load_ready;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s: got no event expected event within 64 cycles", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, 64'(load_ready), 64'(1));
        check({tag, "_flags"}, 64'({dac_valid_out, dac_mode_out, y_values_valid}), 64'(0));
        check({tag, "_dac_mux"}, 64'({dac_out, mux_sel}), 64'(0));
        check({tag, "_y"}, 64'(y_values_out), 64'(0));
    endtask

    task automatic load_x(input logic [39:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            x_value_in = v[i*8 +: 8];
            x_valid_in = 1'b1;
            step();
        end
        x_valid_in = 1'b0;
    endtask

    // Lanes 0..2 written alone; lane 3 written in the commit cycle itself.
    task automatic load_b_commit(input logic [31:0] b, input logic [1:0] d, input bit lst);
        for (int i = 0; i < 4; i++) begin
            b_offset_in = 2'(i);
            b_value_in  = b[i*8 +: 8];
            b_valid_in  = 1'b1;
            if (i == 3) begin
                block_valid_in = 1'b1;
                b_diag_in      = d;
                last_diag_in   = lst;
            end
            step();
        end
        b_valid_in     = 1'b0;
        block_valid_in = 1'b0;
        last_diag_in   = 1'b0;
        b_diag_in      = '0;
    endtask

    task automatic run_diag(input logic [31:0] b, input logic [1:0] d, input bit lst,
                            input logic [7:0] emux, input logic [31:0] eeval,
                            input logic [31:0] adcv, input logic [39:0] ey,
                            input int eval_wait, input bit gate, input bit abort);
        repeat (3) exp_dac.push_back({1'b0, b, emux});
        if (!abort) begin
            repeat (eval_wait + 1) exp_dac.push_back({1'b1, eeval, emux});
            if (lst) exp_y.push_back(ey);
        end
        load_b_commit(b, d, lst);
        if (gate) begin
            wait_high(0, "prog_start");
            x_value_in = 8'd99; x_valid_in = 1'b1;
            b_offset_in = 2'd0; b_value_in = 8'd77; b_valid_in = 1'b1;
            b_diag_in = 2'd2; last_diag_in = 1'b1; block_valid_in = 1'b1;
            adc_in = pd(200, 200, 200, 200); adc_valid_in = 1'b1;
            check("gate_load_ready", 64'(load_ready), 64'(0));
            step();
            x_valid_in = 1'b0; b_valid_in = 1'b0; block_valid_in = 1'b0;
            last_diag_in = 1'b0; b_diag_in = '0; adc_valid_in = 1'b0; adc_in = '0;
        end
        wait_high(1, "eval_start");
        if (abort) begin
            rst = 1'b1;
            #1;
            check_reset_outputs("abort");
            step();
            rst = 1'b0;
            step();
            check("abort_idle_ready", 64'(load_ready), 64'(1));
            return;
        end
        repeat (eval_wait) step();
        adc_in = adcv;
        adc_valid_in = 1'b1;
        step();
        adc_valid_in = 1'b0;
        adc_in = '0;
        wait_high(2, "back_to_idle");
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b_value_in = '0; b_offset_in = '0; b_valid_in = 1'b0; b_diag_in = '0;
        last_diag_in = 1'b0; block_valid_in = 1'b0; x_value_in = '0; x_valid_in = 1'b0;
        adc_in = '0; adc_valid_in = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        check("post_reset_ready", 64'(load_ready), 64'(1));

        // Basic
        load_x({8'd0, pd(1, 2, 3, 4)}, 4);
        run_diag(pd(10, 20, 30, 40), 2'd0, 1'b1, pm(0, 1, 2, 3), pd(1, 2, 3, 4),
                 pd(5, 6, 7, 8), py(5, 6, 7, 8), 1, 1'b0, 1'b0);

        // Rotation across two diagonals without reloading X
        load_x({8'd0, pd(1, 2, 3, 4)}, 4);
        run_diag(pd(5, 6, 7, 8), 2'd1, 1'b0, pm(1, 2, 3, 0), pd(2, 3, 4, 1),
                 pd(1, 1, 1, 1), '0, 0, 1'b0, 1'b0);
        run_diag(pd(5, 6, 7, 8), 2'd2, 1'b1, pm(2, 3, 0, 1), pd(3, 4, 1, 2),
                 pd(2, 2, 2, 2), py(3, 3, 3, 3), 2, 1'b0, 1'b0);

        // Saturation: lane0 1000+200, lane1 5*255, lane2 exactly 1023, lane3 5; gating on 2nd diag
        load_x({8'd0, pd(1, 2, 3, 4)}, 4);
        for (int k = 0; k < 4; k++)
            run_diag(pd(1, 1, 1, 1), 2'd0, 1'b0, pm(0, 1, 2, 3), pd(1, 2, 3, 4),
                     pd(250, 255, 200, 1), '0, 0, (k == 1), 1'b0);
        run_diag(pd(1, 1, 1, 1), 2'd0, 1'b1, pm(0, 1, 2, 3), pd(1, 2, 3, 4),
                 pd(200, 255, 223, 1), py(1023, 1023, 1023, 5), 0, 1'b0, 1'b0);

        // Boundaries: 5th X ignored; lane-3 B write shares the commit cycle
        load_x({8'd5, pd(9, 8, 7, 6)}, 5);
        run_diag(pd(11, 12, 13, 99), 2'd3, 1'b1, pm(3, 0, 1, 2), pd(6, 9, 8, 7),
                 pd(4, 3, 2, 1), py(4, 3, 2, 1), 0, 1'b0, 1'b0);

        // Reset mid-EVAL with non-zero accumulators, then a clean Basic run
        load_x({8'd0, pd(1, 2, 3, 4)}, 4);
        run_diag(pd(10, 20, 30, 40), 2'd0, 1'b0, pm(0, 1, 2, 3), pd(1, 2, 3, 4),
                 pd(9, 9, 9, 9), '0, 0, 1'b0, 1'b0);
        run_diag(pd(10, 20, 30, 40), 2'd0, 1'b1, pm(0, 1, 2, 3), pd(1, 2, 3, 4),
                 '0, '0, 0, 1'b0, 1'b1);
        load_x({8'd0, pd(1, 2, 3, 4)}, 4);
        run_diag(pd(10, 20, 30, 40), 2'd0, 1'b1, pm(0, 1, 2, 3), pd(1, 2, 3, 4),
                 pd(5, 6, 7, 8), py(5, 6, 7, 8), 1, 1'b0, 1'b0);

        repeat (5) step();
        check("dac_queue_drained", 64'(exp_dac.size()), 64'(0));
        check("y_queue_drained", 64'(exp_y.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
